// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, byte addressing helper and iterative-stage FSM encoding
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  // FSM shared by the iterative AES stages
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  // Byte 0 lives in the top bits of the state; returns the MSB position of byte i
  function automatic int byte_slice(input int i);
    return 127 - 8 * i;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational FIPS-197 forward S-box via GF(2^8) inverse and affine map
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t p;
    aes_byte_t x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  aes_byte_t x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, inv;

  // Inverse as x^254 (0 maps to 0), then the affine transform with constant 0x63
  always_comb begin
    x2   = gf_mul(in_byte, in_byte);
    x3   = gf_mul(x2, in_byte);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(x240, x14);
    out_byte = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
  end

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// rtl/aes_sub_bytes_seq.sv - iterative SubBytes stage, LANES S-box lookups per cycle
module aes_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  aes_fsm_e          fsm_q, fsm_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  aes_state_t        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  aes_byte_t         sbox_in  [LANES];
  aes_byte_t         sbox_out [LANES];

  // Select the bytes of the current lane group for the shared S-boxes
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sbox_in[l] = state_q[7'(byte_slice(int'(cnt_q) * LANES + l)) -: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .in_byte  (sbox_in[g]),
      .out_byte (sbox_out[g])
    );
  end

  // Next-state logic: load on accept, substitute one lane group per BUSY cycle, release on handshake
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_data;
          cnt_d   = '0;
          fsm_d   = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          state_d[7'(byte_slice(int'(cnt_q) * LANES + l)) -: 8] = sbox_out[l];
        end
        if (cnt_q == CW'(N - 1)) begin
          fsm_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
    in_ready_d  = (fsm_d == IDLE);
    out_valid_d = (fsm_d == DONE);
  end

  // State, counter and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      cnt_q       <= '0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = state_q;

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// tb/tb_aes_sub_bytes_seq.sv - directed self-checking bench for aes_sub_bytes_seq
module tb_aes_sub_bytes_seq;

  logic         clk;
  logic         rst_n;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data;

  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [127:0] in_data1, out_data1;

  int n_checks;
  int n_fail;

  localparam logic [127:0] ZERO_IN  = 128'h00000000000000000000000000000000;
  localparam logic [127:0] ZERO_EXP = 128'h63636363636363636363636363636363;
  localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] APPB_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] EDGE_IN  = 128'h53ff0053ff0053ff0053ff0053ff0053;
  localparam logic [127:0] EDGE_EXP = 128'hed1663ed1663ed1663ed1663ed1663ed;
  localparam logic [127:0] SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_EXP  = 128'h637c777bf26b6fc53001672bfed7ab76;

  aes_sub_bytes_seq #(.LANES(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  aes_sub_bytes_seq #(.LANES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_data   (in_data1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_data  (out_data1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one block on the LANES=4 instance, check latency and result, then hand it off
  task automatic do_block(input string tag, input logic [127:0] din, input logic [127:0] exp);
    int waited;
    int lat;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq({tag, "_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 128'(lat), 128'(4));
    check_eq({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_in_ready_after"}, 128'(in_ready), 128'(1));
    check_eq({tag, "_out_valid_after"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    logic [127:0] blk [3];
    logic [127:0] bexp [3];
    logic [127:0] held;
    int acc, outs, last_acc, cyc, lat, pulses;
    logic take_acc, take_out;
    logic [127:0] od;

    n_checks  = 0;
    n_fail    = 0;
    in_valid  = 1'b0; in_data  = '0; out_ready  = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;

    // Asynchronous reset takes effect before any clock edge
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_in_ready", 128'(in_ready), 128'(1));
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_out_data", out_data, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_block("zero", ZERO_IN, ZERO_EXP);
    do_block("appb", APPB_IN, APPB_EXP);
    do_block("edge", EDGE_IN, EDGE_EXP);

    // Backpressure in DONE with in_valid/in_data churning
    in_valid = 1'b1;
    in_data  = APPB_IN;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = lat[0];
      in_data  = {4{$urandom}};
      @(posedge clk); #1;
      lat++;
    end
    check_eq("bp_latency", 128'(lat), 128'(4));
    held = out_data;
    check_eq("bp_data", held, APPB_EXP);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_data  = {4{$urandom}};
      @(posedge clk); #1;
      check_eq("bp_out_valid", 128'(out_valid), 128'(1));
      check_eq("bp_out_data", out_data, APPB_EXP);
      check_eq("bp_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp_release_in_ready", 128'(in_ready), 128'(1));
    check_eq("bp_release_out_valid", 128'(out_valid), 128'(0));

    // Reset during the second BUSY cycle abandons the block
    in_valid = 1'b1;
    in_data  = APPB_IN;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_ready", 128'(in_ready), 128'(1));
    check_eq("midrst_out_valid", 128'(out_valid), 128'(0));
    check_eq("midrst_out_data", out_data, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check_eq("midrst_no_pulse", 128'(pulses), 128'(0));
    check_eq("midrst_idle_ready", 128'(in_ready), 128'(1));
    do_block("post_rst", SEQ_IN, SEQ_EXP);

    // Back-to-back stream with out_ready tied high
    blk[0] = ZERO_IN; blk[1] = APPB_IN; blk[2] = SEQ_IN;
    bexp[0] = ZERO_EXP; bexp[1] = APPB_EXP; bexp[2] = SEQ_EXP;
    out_ready = 1'b1;
    acc = 0; outs = 0; last_acc = 0; cyc = 0;
    while (outs < 3 && cyc < 100) begin
      in_valid = (acc < 3);
      in_data  = (acc < 3) ? blk[acc] : '0;
      take_acc = in_valid && in_ready;
      take_out = out_valid && out_ready;
      od       = out_data;
      @(posedge clk); #1;
      cyc++;
      if (take_acc) begin
        if (acc > 0) check_eq("b2b_spacing", 128'(cyc - last_acc), 128'(6));
        last_acc = cyc;
        acc++;
      end
      if (take_out) begin
        check_eq("b2b_out", od, bexp[outs]);
        outs++;
      end
    end
    check_eq("b2b_count", 128'(outs), 128'(3));
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // LANES=1 instance: sixteen substitution cycles
    check_eq("l1_ready", 128'(in_ready1), 128'(1));
    in_valid1 = 1'b1;
    in_data1  = SEQ_IN;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    in_data1  = '1;
    lat = 0;
    while (!out_valid1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("l1_latency", 128'(lat), 128'(16));
    check_eq("l1_data", out_data1, SEQ_EXP);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check_eq("l1_in_ready_after", 128'(in_ready1), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
